// File: rtl/commit_unit_pkg.sv
// Shared types and constants for the commit stage: FSM encoding, entry layout, widths.
package commit_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } commit_state_e;

  // Entry layout, MSB first: {wena, waddr, wdata, pc, ebreak}
  typedef struct packed {
    logic                  wena;
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
    logic [XLEN-1:0]       pc;
    logic                  ebreak;
  } commit_entry_t;

  localparam int ENTRY_W    = 1 + REG_ADDR_W + XLEN + XLEN + 1;
  localparam int OFF_EBREAK = 0;
  localparam int OFF_PC     = 1;
  localparam int OFF_WDATA  = OFF_PC + XLEN;
  localparam int OFF_WADDR  = OFF_WDATA + XLEN;
  localparam int OFF_WENA   = OFF_WADDR + REG_ADDR_W;

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is read combinationally.
module commit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 71
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/commit_unit.sv
// In-order commit stage: buffers execute results and retires one per cycle to the register file.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  exu_valid_i,
  output logic                  exu_ready_o,
  input  logic                  exu_wena_i,
  input  logic [REG_ADDR_W-1:0] exu_waddr_i,
  input  logic [XLEN-1:0]       exu_wdata_i,
  input  logic [XLEN-1:0]       exu_pc_i,
  input  logic                  exu_ebreak_i,
  input  logic                  commit_hold_i,
  output logic                  commit_valid_o,
  output logic                  commit_wena_o,
  output logic [REG_ADDR_W-1:0] commit_waddr_o,
  output logic [XLEN-1:0]       commit_wdata_o,
  output logic [XLEN-1:0]       commit_pc_o,
  output logic                  halt_o,
  output logic [63:0]           instret_o,
  output commit_state_e         state_o
);

  // Handshake: a result transfers on a rising edge where exu_valid_i && exu_ready_o.
  // exu_ready_o is decoded from registered state only, never from exu_valid_i.

  commit_state_e state, state_next;
  commit_entry_t push_entry;
  commit_entry_t head_entry;
  logic [ENTRY_W-1:0] head_bits;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  assign exu_ready_o = !fifo_full && (state == RUN);
  assign push        = exu_valid_i && exu_ready_o;
  assign pop         = (state == RUN) && !fifo_empty && !commit_hold_i;
  assign state_o     = state;

  assign push_entry.wena   = exu_wena_i;
  assign push_entry.waddr  = exu_waddr_i;
  assign push_entry.wdata  = exu_wdata_i;
  assign push_entry.pc     = exu_pc_i;
  assign push_entry.ebreak = exu_ebreak_i;
  assign head_entry        = commit_entry_t'(head_bits);

  commit_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (pop && head_entry.ebreak) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  // Payload registers hold their last value when no entry retires.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      commit_valid_o <= 1'b0;
      commit_wena_o  <= 1'b0;
      commit_waddr_o <= '0;
      commit_wdata_o <= '0;
      commit_pc_o    <= '0;
      halt_o         <= 1'b0;
      instret_o      <= '0;
    end else begin
      commit_valid_o <= pop;
      if (pop) begin
        commit_wena_o  <= head_entry.wena;
        commit_waddr_o <= head_entry.waddr;
        commit_wdata_o <= head_entry.wdata;
        commit_pc_o    <= head_entry.pc;
        instret_o      <= instret_o + 64'd1;
      end
      if (state_next == HALT) halt_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: reset, single write, streaming, backpressure, halt, reset mid-stream.
module tb_commit_unit;
  import commit_unit_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        exu_valid_i;
  logic        exu_ready_o;
  logic        exu_wena_i;
  logic [4:0]  exu_waddr_i;
  logic [31:0] exu_wdata_i;
  logic [31:0] exu_pc_i;
  logic        exu_ebreak_i;
  logic        commit_hold_i;
  logic        commit_valid_o;
  logic        commit_wena_o;
  logic [4:0]  commit_waddr_o;
  logic [31:0] commit_wdata_o;
  logic [31:0] commit_pc_o;
  logic        halt_o;
  logic [63:0] instret_o;
  commit_state_e state_o;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_instret;

  commit_unit #(.DEPTH(4)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .exu_valid_i    (exu_valid_i),
    .exu_ready_o    (exu_ready_o),
    .exu_wena_i     (exu_wena_i),
    .exu_waddr_i    (exu_waddr_i),
    .exu_wdata_i    (exu_wdata_i),
    .exu_pc_i       (exu_pc_i),
    .exu_ebreak_i   (exu_ebreak_i),
    .commit_hold_i  (commit_hold_i),
    .commit_valid_o (commit_valid_o),
    .commit_wena_o  (commit_wena_o),
    .commit_waddr_o (commit_waddr_o),
    .commit_wdata_o (commit_wdata_o),
    .commit_pc_o    (commit_pc_o),
    .halt_o         (halt_o),
    .instret_o      (instret_o),
    .state_o        (state_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [31:0] pc, input logic eb);
    exu_valid_i  = v;
    exu_wena_i   = we;
    exu_waddr_i  = wa;
    exu_wdata_i  = wd;
    exu_pc_i     = pc;
    exu_ebreak_i = eb;
  endtask

  task automatic chk_commit(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic [31:0] pc);
    chk({tag, "_valid"}, 64'(commit_valid_o), 64'd1);
    chk({tag, "_wena"},  64'(commit_wena_o),  64'(we));
    chk({tag, "_waddr"}, 64'(commit_waddr_o), 64'(wa));
    chk({tag, "_wdata"}, 64'(commit_wdata_o), 64'(wd));
    chk({tag, "_pc"},    64'(commit_pc_o),    64'(pc));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},   64'(commit_valid_o), 64'd0);
    chk({tag, "_wena"},    64'(commit_wena_o),  64'd0);
    chk({tag, "_waddr"},   64'(commit_waddr_o), 64'd0);
    chk({tag, "_wdata"},   64'(commit_wdata_o), 64'd0);
    chk({tag, "_pc"},      64'(commit_pc_o),    64'd0);
    chk({tag, "_halt"},    64'(halt_o),         64'd0);
    chk({tag, "_instret"}, instret_o,           64'd0);
    chk({tag, "_state"},   64'(state_o),        64'(RUN));
  endtask

  initial begin
    reset_n       = 1'b0;
    commit_hold_i = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    exp_instret   = 64'd0;

    // Reset values with no clock edge yet
    #1;
    chk_reset_vals("rst0");
    chk("rst0_ready", 64'(exu_ready_o), 64'd1);
    #7;
    reset_n = 1'b1;
    tick();
    chk("rst_rel_ready", 64'(exu_ready_o), 64'd1);
    chk("rst_rel_valid", 64'(commit_valid_o), 64'd0);

    // Single write
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h8000_0000, 1'b0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    chk("single_lat", 64'(commit_valid_o), 64'd0);
    tick();
    exp_instret = 64'd1;
    chk_commit("single", 1'b1, 5'd5, 32'hDEADBEEF, 32'h8000_0000);
    chk("single_instret", instret_o, exp_instret);
    tick();
    chk("single_pulse", 64'(commit_valid_o), 64'd0);
    chk("single_hold_wdata", 64'(commit_wdata_o), 64'hDEADBEEF);

    // Streaming: 8 back-to-back pushes, data 1..8
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 5'(i + 1), 32'(i + 1), 32'h1000 + 32'(4 * i), 1'b0);
      chk($sformatf("stream_ready%0d", i), 64'(exu_ready_o), 64'd1);
      tick();
      if (i > 0) chk_commit($sformatf("stream%0d", i - 1), 1'b1, 5'(i), 32'(i), 32'h1000 + 32'(4 * (i - 1)));
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    tick();
    chk_commit("stream7", 1'b1, 5'd8, 32'd8, 32'h101C);
    exp_instret = exp_instret + 64'd8;
    chk("stream_instret", instret_o, exp_instret);

    // Backpressure: hold while offering 5 results, only 4 fit
    commit_hold_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 5'd3, 32'hA0 + 32'(i), 32'h2000 + 32'(4 * i), 1'b0);
      chk($sformatf("bp_ready%0d", i), 64'(exu_ready_o), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) begin
        tick();
        chk($sformatf("bp_held%0d", i), 64'(commit_valid_o), 64'd0);
      end
    end
    tick();
    chk("bp_full_ready", 64'(exu_ready_o), 64'd0);
    chk("bp_full_valid", 64'(commit_valid_o), 64'd0);
    commit_hold_i = 1'b0;
    tick();
    chk_commit("bp_a0", 1'b1, 5'd3, 32'hA0, 32'h2000);
    chk("bp_ready_freed", 64'(exu_ready_o), 64'd1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    chk_commit("bp_a1", 1'b1, 5'd3, 32'hA1, 32'h2004);
    tick();
    chk_commit("bp_a2", 1'b1, 5'd3, 32'hA2, 32'h2008);
    tick();
    chk_commit("bp_a3", 1'b1, 5'd3, 32'hA3, 32'h200C);
    tick();
    chk_commit("bp_a4", 1'b1, 5'd3, 32'hA4, 32'h2010);
    tick();
    chk("bp_drained", 64'(commit_valid_o), 64'd0);
    exp_instret = exp_instret + 64'd5;
    chk("bp_instret", instret_o, exp_instret);

    // Halt: A (x1<-1), ebreak B, C (x2<-2)
    drive(1'b1, 1'b1, 5'd1, 32'd1, 32'h300, 1'b0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 32'h304, 1'b1);
    tick();
    chk_commit("halt_a", 1'b1, 5'd1, 32'd1, 32'h300);
    chk("halt_a_halt", 64'(halt_o), 64'd0);
    drive(1'b1, 1'b1, 5'd2, 32'd2, 32'h308, 1'b0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    chk_commit("halt_b", 1'b0, 5'd0, 32'd0, 32'h304);
    chk("halt_b_halt", 64'(halt_o), 64'd1);
    chk("halt_b_state", 64'(state_o), 64'(HALT));
    exp_instret = exp_instret + 64'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("halt_novalid%0d", i), 64'(commit_valid_o), 64'd0);
      chk($sformatf("halt_ready%0d", i), 64'(exu_ready_o), 64'd0);
    end
    chk("halt_instret", instret_o, exp_instret);
    chk("halt_sticky", 64'(halt_o), 64'd1);

    // Reset mid-cycle clears halt and everything else immediately
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("rst1");
    #2;
    reset_n = 1'b1;
    tick();
    chk("rst1_ready", 64'(exu_ready_o), 64'd1);

    // Reset mid-stream: 3 buffered under hold, then reset
    commit_hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'd7, 32'hB0 + 32'(i), 32'h400 + 32'(4 * i), 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("rst2");
    #2;
    reset_n = 1'b1;
    commit_hold_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rst2_novalid%0d", i), 64'(commit_valid_o), 64'd0);
    end
    chk("rst2_instret", instret_o, 64'd0);
    drive(1'b1, 1'b1, 5'd9, 32'h55, 32'h500, 1'b0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    tick();
    chk_commit("rst2_new", 1'b1, 5'd9, 32'h55, 32'h500);
    chk("rst2_new_instret", instret_o, 64'd1);
    tick();
    chk("rst2_end_valid", 64'(commit_valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
